instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Upstream feeder for the cpu core: buffers 20-bit instruction words from a
//  loader (file reader or program ROM) via valid/ready handshake and issues one
//  word per clock on the cpu's 20-bit instruction input. Inserts a NOP bubble
//  when the queue is empty and stops issuing after a HALT word.
// PARAMETERS
//  IW        20        instruction word width (matches cpu input)
//  DEPTH     8         queue entries; power of 2, >= 2
//  NOP_WORD  20'h00000 word driven on instr during bubbles, reset and flush
//  HALT_WORD 20'hFFFFF issuing this word moves the FSM to HALT
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  wr_valid   in   1          loader has a word on wr_data
//  wr_data    in   IW         instruction word from loader
//  wr_ready   out  1          queue can accept; write when wr_valid&&wr_ready
//  cpu_stall  in   1          hold issued word; no pop this cycle
//  flush      in   1          synchronous clear of queue, pc and FSM
//  instr      out  IW         registered word to cpu instruction input
//  instr_vld  out  1          instr is a real queued word (0 = bubble)
//  pc         out  16         number of words issued since reset/flush
//  count      out  log2(D)+1  current occupancy
//  halted     out  1          FSM is in HALT
// BEHAVIOUR
//  - Reset (async, rst_n=0): queue empty, count=0, instr=NOP_WORD,
//    instr_vld=0, pc=0, halted=0, FSM=IDLE. All outputs registered.
//  - wr_ready = !full && !flush && !halted.
//  - Pop condition: !cpu_stall && count!=0 && FSM!=HALT && !flush.
//  - On pop: instr<=head, instr_vld<=1, pc<=pc+1 (wraps 16'hFFFF->0).
//  - No pop, not stalled: instr<=NOP_WORD, instr_vld<=0 (bubble).
//  - cpu_stall=1: instr, instr_vld, pc hold; pushes still accepted.
//  - Latency: word accepted at edge k (empty queue, no stall) is on instr
//    after edge k+1. A push and a pop in the same cycle leave count unchanged.
//  - Ordering strictly FIFO; read/write pointers wrap modulo DEPTH.
//  - Full: wr_ready=0; the same-cycle pop does not reopen wr_ready until
//    the next cycle.
//  - FSM: IDLE (count==0) -> RUN on first accepted write.
//    RUN -> IDLE when the last word pops with no simultaneous push.
//    RUN -> HALT when the word popped equals HALT_WORD; that word is still
//    issued with instr_vld=1. HALT -> IDLE only on flush.
//    In HALT: no pops, instr=NOP_WORD, instr_vld=0, queue contents kept.
//  - flush=1 (wins over push, pop and stall): queue emptied, count=0, pc=0,
//    instr=NOP_WORD, instr_vld=0, halted=0, FSM=IDLE; concurrent write dropped.
//  - Reset mid-operation: immediate return to reset values, no partial issue.
// CONFIGURATION
//  IFQ_STATS_EN defined: adds outputs bubble_cnt[15:0] and stall_cnt[15:0].
//    bubble_cnt increments on each bubble cycle in RUN/IDLE (not HALT).
//    stall_cnt increments on each cycle with cpu_stall=1.
//    Both saturate at 16'hFFFF; both clear on reset and flush.
//  IFQ_STATS_EN undefined: ports and counters absent; core behaviour identical.
// TESTING
//  - Reset: rst_n=0 mid-stream -> instr=20'h00000, instr_vld=0, pc=0,
//    count=0 immediately, without waiting for a clock edge.
//  - Stream: write 20'h12345, 20'h0A0B1, 20'h3C3C3 on consecutive cycles ->
//    issued in order one per clock, first issued after edge k+1, pc=3.
//  - Full/backpressure: DEPTH=8, stall=1, write 9 words -> wr_ready=0 after
//    8th; 9th held by loader; release stall -> all 9 issued in order.
//  - Bubble: queue empty for 3 cycles -> instr=NOP_WORD, instr_vld=0 each
//    cycle, pc unchanged; bubble_cnt=3 with IFQ_STATS_EN.
//  - Halt: queue 20'h00111, 20'hFFFFF, 20'h00222 -> first two issued,
//    halted=1, 20'h00222 stays queued (count=1); flush -> count=0, pc=0,
//    halted=0.
//  - Flush+write same cycle: count=4, flush=1 and wr_valid=1 -> count=0,
//    written word dropped, next cycle instr_vld=0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Buffers instruction words from a loader (valid/ready) and issues one word
//   per clock to the cpu instruction input. Drives NOP_WORD bubbles while the
//   queue is empty and stops issuing once HALT_WORD has been issued (until
//   flush).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_valid, wr_data    loader word; accepted when wr_valid && wr_ready
//   wr_ready             queue can accept (not full, not flushing, not halted)
//   cpu_stall            hold the issued word, no pop this cycle
//   flush                synchronous clear of queue, pc and FSM
//   instr, instr_vld     registered word to the cpu; instr_vld=0 marks a bubble
//   pc                   words issued since reset/flush (wraps)
//   count                queue occupancy
//   halted               FSM is in HALT
//
// Build option
//   IFQ_STATS_EN: adds saturating bubble_cnt / stall_cnt outputs.

module instr_fetch_queue #(
  parameter int unsigned    IW        = 20,
  parameter int unsigned    DEPTH     = 8,
  parameter logic [IW-1:0]  NOP_WORD  = '0,
  parameter logic [IW-1:0]  HALT_WORD = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [IW-1:0]            wr_data,
  output logic                     wr_ready,
  input  logic                     cpu_stall,
  input  logic                     flush,
  output logic [IW-1:0]            instr,
  output logic                     instr_vld,
  output logic [15:0]              pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]              bubble_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            instr_vld_q, instr_vld_d;
  logic [15:0]     pc_q, pc_d;
  logic            push, pop, full;
  logic [IW-1:0]   head;

  assign full = (count_q == CW'(DEPTH));
  assign head = mem_q[rd_ptr_q];
  assign push = wr_valid && wr_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (push) state_d = StRun;
      StRun: begin
        if (pop && head == HALT_WORD)                   state_d = StHalt;
        else if (pop && !push && count_q == CW'(1))     state_d = StIdle;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // FSM: outputs / handshake decode. Full is taken from the registered count,
  // so a pop from a full queue only reopens wr_ready on the following cycle.
  always_comb begin
    halted   = (state_q == StHalt);
    wr_ready = !full && !flush && !halted;
    pop      = !cpu_stall && (count_q != '0) && !halted && !flush;
  end

  // Datapath next state; flush overrides push, pop and stall.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    pc_d        = pc_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      instr_d     = NOP_WORD;
      instr_vld_d = 1'b0;
      pc_d        = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      if (pop) begin
        instr_d     = head;
        instr_vld_d = 1'b1;
        pc_d        = pc_q + 16'd1;
      end else if (!cpu_stall) begin
        instr_d     = NOP_WORD;
        instr_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      instr_q     <= NOP_WORD;
      instr_vld_q <= 1'b0;
      pc_q        <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      pc_q        <= pc_d;
    end
  end

  // Storage needs no reset; occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign instr     = instr_q;
  assign instr_vld = instr_vld_q;
  assign pc        = pc_q;
  assign count     = count_q;

`ifdef IFQ_STATS_EN
  logic [15:0] bubble_cnt_q, stall_cnt_q;
  logic        bubble;

  assign bubble = !cpu_stall && !pop && !halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if (flush) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (bubble && bubble_cnt_q != 16'hFFFF)   bubble_cnt_q <= bubble_cnt_q + 16'd1;
      if (cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q  <= stall_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: reset, bubbles, streaming, full
// backpressure, halt, flush with concurrent write, and async reset mid-stream.

module tb_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [19:0] wr_data;
  logic        wr_ready;
  logic        cpu_stall;
  logic        flush;
  logic [19:0] instr;
  logic        instr_vld;
  logic [15:0] pc;
  logic [3:0]  count;
  logic        halted;
`ifdef IFQ_STATS_EN
  logic [15:0] bubble_cnt;
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_queue #(
    .IW        (20),
    .DEPTH     (8),
    .NOP_WORD  (20'h00000),
    .HALT_WORD (20'hFFFFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .cpu_stall (cpu_stall),
    .flush     (flush),
    .instr     (instr),
    .instr_vld (instr_vld),
    .pc        (pc),
    .count     (count),
    .halted    (halted)
`ifdef IFQ_STATS_EN
    ,
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] words [9];
  int          idx;
  int          got_n;
  logic        acc;

  initial begin
    rst_n = 1'b1; wr_valid = 1'b0; wr_data = '0; cpu_stall = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_instr", instr, 20'h00000);
    check("rst_vld", instr_vld, 0);
    check("rst_pc", pc, 0);
    check("rst_count", count, 0);
    check("rst_halted", halted, 0);
    check("rst_wr_ready", wr_ready, 1);
    tick();
    rst_n = 1'b1;

    // Bubbles on an empty queue
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bub_instr", instr, 20'h00000);
      check("bub_vld", instr_vld, 0);
      check("bub_pc", pc, 0);
    end
`ifdef IFQ_STATS_EN
    check("bub_cnt", bubble_cnt, 3);
`endif

    // Stream of three words
    wr_valid = 1'b1; wr_data = 20'h12345;
    tick();
    check("str_k_vld", instr_vld, 0);
    check("str_k_count", count, 1);
    wr_data = 20'h0A0B1;
    tick();
    check("str_w0", instr, 20'h12345);
    check("str_w0_vld", instr_vld, 1);
    check("str_w0_pc", pc, 1);
    wr_data = 20'h3C3C3;
    tick();
    check("str_w1", instr, 20'h0A0B1);
    check("str_w1_pc", pc, 2);
    wr_valid = 1'b0;
    tick();
    check("str_w2", instr, 20'h3C3C3);
    check("str_pc3", pc, 3);
    check("str_count0", count, 0);
    tick();
    check("str_bub_vld", instr_vld, 0);
    check("str_bub_pc", pc, 3);

    // Full / backpressure: stall and offer 9 words
    for (int i = 0; i < 9; i++) words[i] = 20'h10000 + 20'(i * 17);
    idx = 0;
    cpu_stall = 1'b1;
    for (int c = 0; c < 12; c++) begin
      wr_valid = (idx < 9);
      wr_data  = words[idx < 9 ? idx : 8];
      acc = wr_valid && wr_ready;
      tick();
      if (acc) idx++;
    end
    check("full_count", count, 8);
    check("full_wr_ready", wr_ready, 0);
    check("full_pc_hold", pc, 3);
    check("full_vld_hold", instr_vld, 0);
`ifdef IFQ_STATS_EN
    check("stall_cnt", stall_cnt, 12);
`endif
    cpu_stall = 1'b0;
    got_n = 0;
    for (int c = 0; c < 30 && got_n < 9; c++) begin
      wr_valid = (idx < 9);
      wr_data  = words[idx < 9 ? idx : 8];
      acc = wr_valid && wr_ready;
      tick();
      if (acc) idx++;
      if (c == 0) check("full_pop_no_reopen", count, 7);
      if (instr_vld) begin
        check($sformatf("full_order%0d", got_n), instr, words[got_n]);
        got_n++;
      end
    end
    wr_valid = 1'b0;
    check("full_all_issued", got_n, 9);
    check("full_pc12", pc, 12);

    // Halt
    wr_valid = 1'b1; wr_data = 20'h00111;
    tick();
    wr_data = 20'hFFFFF;
    tick();
    check("halt_w0", instr, 20'h00111);
    wr_data = 20'h00222;
    tick();
    wr_valid = 1'b0;
    check("halt_word", instr, 20'hFFFFF);
    check("halt_word_vld", instr_vld, 1);
    check("halt_pc", pc, 14);
    check("halt_halted", halted, 1);
    tick();
    check("halt_nop", instr, 20'h00000);
    check("halt_vld0", instr_vld, 0);
    check("halt_count", count, 1);
    check("halt_wr_ready", wr_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_pc", pc, 0);
    check("flush_halted", halted, 0);
`ifdef IFQ_STATS_EN
    check("flush_bub_cnt", bubble_cnt, 0);
`endif

    // Flush with concurrent write
    cpu_stall = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 20'h00500 + 20'(i);
      tick();
    end
    check("fw_count4", count, 4);
    flush = 1'b1; wr_data = 20'h0BEEF;
    #1;
    check("fw_wr_ready", wr_ready, 0);
    tick();
    check("fw_count0", count, 0);
    flush = 1'b0; wr_valid = 1'b0; cpu_stall = 1'b0;
    tick();
    check("fw_vld0", instr_vld, 0);
    check("fw_dropped", count, 0);

    // Asynchronous reset mid-stream
    wr_valid = 1'b1; wr_data = 20'h00777;
    tick();
    wr_data = 20'h00888;
    tick();
    check("mid_pre_vld", instr_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_instr", instr, 20'h00000);
    check("mid_rst_vld", instr_vld, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_count", count, 0);
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
